serial_add_ctrl: RTL

- Bit-serial adder controller: sequences one instance of the team's 1-bit full_adder (ports a, b, cin, s, cout) over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Sits between a requester (start/done handshake) and the full_adder datapath.
- Trades latency for area on the Spartan-3 clock design.

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder is reused over WIDTH clocks
// to form {cout, sum} = op_a + op_b + cin, least significant bit first.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    // Single-bit sum and carry
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH:0]   s_cat;
    logic [WIDTH-1:0] sh_s_nxt;

    full_adder fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next result shift value; concatenating before slicing keeps WIDTH=1 legal
    always_comb begin
        s_cat    = {fa_s, sh_s};
        sh_s_nxt = s_cat[WIDTH:1];
    end

    // Controller FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= op_a;
                        sh_b  <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_s  <= sh_s_nxt;
                    carry <= fa_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= sh_s_nxt;
                        cout  <= fa_cout;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
